// File: rtl/store_req_issue_pkg.sv
// Shared types for the data-side store request initiator: store opcodes,
// FSM states, the encoded request bundle and a strobe-to-size helper.
package store_req_issue_pkg;

  typedef enum logic [2:0] {
    OP_SW  = 3'b000,
    OP_SB  = 3'b001,
    OP_SH  = 3'b010,
    OP_SWL = 3'b011,
    OP_SWR = 3'b100
  } store_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
  } store_req_t;

  // Bus size follows the number of enabled lanes; three lanes still need a word beat.
  function automatic logic [1:0] strb_size(input logic [3:0] strb);
    logic [2:0] cnt;
    cnt = {2'b00, strb[0]} + {2'b00, strb[1]} + {2'b00, strb[2]} + {2'b00, strb[3]};
    case (cnt)
      3'd1:    strb_size = SIZE_BYTE;
      3'd2:    strb_size = SIZE_HALF;
      3'd3:    strb_size = SIZE_WORD;
      3'd4:    strb_size = SIZE_WORD;
      default: strb_size = SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/store_req_issue_encode.sv
// Combinational store encoder: places rt bytes into the lanes selected by
// opcode and address low bits, producing strobe, data, size and address.
module store_encode
  import store_req_issue_pkg::*;
(
  input  store_op_e   i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rt,
  output store_req_t  o_req
);

  logic [1:0] w_a;
  assign w_a = i_addr[1:0];

  // Lane placement per opcode; size is derived from the strobe afterwards.
  always_comb begin
    o_req = '0;
    case (i_op)
      OP_SW: begin
        o_req.addr  = i_addr;
        o_req.wdata = i_rt;
        o_req.strb  = 4'b1111;
      end
      OP_SB: begin
        o_req.addr  = i_addr;
        o_req.wdata = {4{i_rt[7:0]}};
        o_req.strb  = 4'b0001 << w_a;
      end
      OP_SH: begin
        o_req.addr  = i_addr;
        o_req.wdata = {2{i_rt[15:0]}};
        if (w_a[1]) begin
          o_req.strb = 4'b1100;
        end else begin
          o_req.strb = 4'b0011;
        end
      end
      OP_SWL: begin
        o_req.addr = {i_addr[31:2], 2'b00};
        case (w_a)
          2'd0:    begin o_req.strb = 4'b0001; o_req.wdata = {24'h000000, i_rt[31:24]}; end
          2'd1:    begin o_req.strb = 4'b0011; o_req.wdata = {16'h0000, i_rt[31:16]}; end
          2'd2:    begin o_req.strb = 4'b0111; o_req.wdata = {8'h00, i_rt[31:8]}; end
          default: begin o_req.strb = 4'b1111; o_req.wdata = i_rt; end
        endcase
      end
      OP_SWR: begin
        o_req.addr = i_addr;
        case (w_a)
          2'd0:    begin o_req.strb = 4'b1111; o_req.wdata = i_rt; end
          2'd1:    begin o_req.strb = 4'b1110; o_req.wdata = {i_rt[23:0], 8'h00}; end
          2'd2:    begin o_req.strb = 4'b1100; o_req.wdata = {i_rt[15:0], 16'h0000}; end
          default: begin o_req.strb = 4'b1000; o_req.wdata = {i_rt[7:0], 24'h000000}; end
        endcase
      end
      default: o_req = '0;
    endcase
    o_req.size = strb_size(o_req.strb);
  end

endmodule

// File: rtl/store_req_issue.sv
// Store request initiator: captures an encoded store from execute and runs one
// write at a time over the req/addr_ok/data_ok bus, gating execute advance.
module store_req_issue
  import store_req_issue_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_valid,
  input  logic        es_is_store,
  input  logic [2:0]  es_store_op,
  input  logic [31:0] es_addr,
  input  logic [31:0] es_rt_value,
  input  logic        es_flush,
  input  logic        st_advance,
  output logic        st_ready_go,
  output logic        st_busy,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  state_e     r_state;
  state_e     w_next;
  logic       r_cancel;
  logic       w_cancel_next;
  logic       w_capture;
  logic       w_ready_go;
  logic       r_req;
  logic       r_busy;
  store_req_t r_fields;
  store_req_t w_enc;
  store_op_e  w_op;

  assign w_op = store_op_e'(es_store_op);

  store_encode u_encode (
    .i_op   (w_op),
    .i_addr (es_addr),
    .i_rt   (es_rt_value),
    .o_req  (w_enc)
  );

  // State, cancel flag and the request bundle; bundle only changes at capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cancel <= 1'b0;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
      r_fields <= '0;
    end else begin
      r_state  <= w_next;
      r_cancel <= w_cancel_next;
      r_req    <= (w_next == ST_REQ);
      r_busy   <= (w_next != ST_IDLE);
      if (w_capture) begin
        r_fields <= w_enc;
      end else begin
        r_fields <= r_fields;
      end
    end
  end

  // Next state; a flushed store still completes its bus write but never reports ready.
  always_comb begin
    w_next        = r_state;
    w_cancel_next = r_cancel;
    w_capture     = 1'b0;
    w_ready_go    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (es_valid && es_is_store && !es_flush && !st_advance) begin
          w_next        = ST_REQ;
          w_capture     = 1'b1;
          w_cancel_next = 1'b0;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (es_flush) begin
          w_cancel_next = 1'b1;
        end else begin
          w_cancel_next = r_cancel;
        end
        if (data_addr_ok) begin
          w_next = ST_WAIT;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          w_ready_go = !r_cancel;
          if (r_cancel || es_flush || st_advance) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_DONE;
          end
          w_cancel_next = 1'b0;
        end else if (es_flush) begin
          w_cancel_next = 1'b1;
        end else begin
          w_cancel_next = r_cancel;
        end
      end
      ST_DONE: begin
        w_ready_go = 1'b1;
        if (es_flush || st_advance) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: begin
        w_next        = ST_IDLE;
        w_cancel_next = 1'b0;
      end
    endcase
  end

  assign st_ready_go = w_ready_go;
  assign st_busy     = r_busy;
  assign data_req    = r_req;
  assign data_wr     = r_req;
  assign data_size   = r_fields.size;
  assign data_addr   = r_fields.addr;
  assign data_wstrb  = r_fields.strb;
  assign data_wdata  = r_fields.wdata;

endmodule

// File: tb/tb_store_req_issue.sv
// Scoreboard bench for store_req_issue: the driver pushes byte-lane reference
// requests, a negedge monitor pops and compares them at each address handshake.
module tb_store_req_issue;

  logic        clk;
  logic        resetn;
  logic        es_valid;
  logic        es_is_store;
  logic [2:0]  es_store_op;
  logic [31:0] es_addr;
  logic [31:0] es_rt_value;
  logic        es_flush;
  logic        st_advance;
  logic        st_ready_go;
  logic        st_busy;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  store_req_issue dut (
    .clk          (clk),
    .resetn       (resetn),
    .es_valid     (es_valid),
    .es_is_store  (es_is_store),
    .es_store_op  (es_store_op),
    .es_addr      (es_addr),
    .es_rt_value  (es_rt_value),
    .es_flush     (es_flush),
    .st_advance   (st_advance),
    .st_ready_go  (st_ready_go),
    .st_busy      (st_busy),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: memory-lane view of each store, built byte by byte.
  function automatic exp_t model(input int op, input logic [31:0] addr, input logic [31:0] rt);
    exp_t e;
    int a;
    int n;
    logic [7:0] b[4];
    a = int'(addr[1:0]);
    for (int k = 0; k < 4; k++) b[k] = rt[8*k +: 8];
    e.addr = addr; e.wdata = 32'h0; e.strb = 4'h0; n = 4;
    case (op)
      0: begin for (int k = 0; k < 4; k++) begin e.wdata[8*k +: 8] = b[k]; e.strb[k] = 1'b1; end n = 4; end
      1: begin for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = b[0]; e.strb[a] = 1'b1; n = 1; end
      2: begin
        for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = b[k % 2];
        e.strb[(a/2)*2] = 1'b1; e.strb[(a/2)*2 + 1] = 1'b1; n = 2;
      end
      3: begin
        e.addr = addr & 32'hFFFF_FFFC;
        for (int k = 0; k <= a; k++) begin e.wdata[8*k +: 8] = b[3 - a + k]; e.strb[k] = 1'b1; end
        n = a + 1;
      end
      default: begin
        for (int k = a; k < 4; k++) begin e.wdata[8*k +: 8] = b[k - a]; e.strb[k] = 1'b1; end
        n = 4 - a;
      end
    endcase
    e.size = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    return e;
  endfunction

  // Monitor: field checks at each accepted request, stability while stalled.
  logic prev_pending = 1'b0;
  exp_t prev;
  always @(negedge clk) begin
    if (resetn && data_req) begin
      check("data_wr", {31'h0, data_wr}, 32'h1);
      if (prev_pending) begin
        check("stall_addr",  data_addr,  prev.addr);
        check("stall_wdata", data_wdata, prev.wdata);
        check("stall_strb",  {28'h0, data_wstrb}, {28'h0, prev.strb});
        check("stall_size",  {30'h0, data_size},  {30'h0, prev.size});
      end
      if (data_addr_ok) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got request at %h expected none", data_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("req_addr",  data_addr,  e.addr);
          check("req_wdata", data_wdata, e.wdata);
          check("req_strb",  {28'h0, data_wstrb}, {28'h0, e.strb});
          check("req_size",  {30'h0, data_size},  {30'h0, e.size});
        end
        prev_pending = 1'b0;
      end else begin
        prev_pending = 1'b1;
        prev.addr = data_addr; prev.wdata = data_wdata;
        prev.strb = data_wstrb; prev.size = data_size;
      end
    end else begin
      prev_pending = 1'b0;
    end
  end

  // One store; flush_mode 0 none, 1 in REQ, 2 in WAIT, 3 in DONE, 4 at capture.
  task automatic run_store(input int op, input logic [31:0] addr, input logic [31:0] rt,
                           input int alat, input int dlat, input int flush_mode,
                           input bit adv_with, input int hold);
    bit cancelled;
    int req_cyc;
    cancelled = 1'b0;
    es_valid = 1'b1; es_is_store = 1'b1; es_store_op = op[2:0];
    es_addr = addr; es_rt_value = rt; st_advance = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    es_flush = (flush_mode == 4);
    if (flush_mode == 4) begin
      @(posedge clk); #1;
      es_valid = 1'b0; es_flush = 1'b0;
      check("flush_capture_req",  {31'h0, data_req}, 32'h0);
      check("flush_capture_busy", {31'h0, st_busy},  32'h0);
      return;
    end
    exp_q.push_back(model(op, addr, rt));
    @(posedge clk); #1;
    req_cyc = cyc;
    for (int i = 0; i <= alat; i++) begin
      data_addr_ok = (i == alat);
      es_flush = (flush_mode == 1 && i == 0);
      if (es_flush) begin cancelled = 1'b1; es_valid = 1'b0; end
      #1;
      check("req_high", {31'h0, data_req}, 32'h1);
      check("rg_in_req", {31'h0, st_ready_go}, 32'h0);
      @(posedge clk); #1;
      es_flush = 1'b0;
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i <= dlat; i++) begin
      data_data_ok = (i == dlat);
      es_flush = (flush_mode == 2 && i == 0);
      if (es_flush) begin cancelled = 1'b1; es_valid = 1'b0; end
      st_advance = (i == dlat) && adv_with && !cancelled;
      #1;
      check("req_low_wait", {31'h0, data_req}, 32'h0);
      check("rg_wait", {31'h0, st_ready_go}, {31'h0, (i == dlat) && !cancelled});
      if (i == dlat && !cancelled) check("rg_latency", cyc - req_cyc, alat + dlat + 1);
      @(posedge clk); #1;
      es_flush = 1'b0;
    end
    data_data_ok = 1'b0;
    if (!cancelled && !adv_with) begin
      for (int i = 0; i <= hold; i++) begin
        es_flush = (flush_mode == 3 && i == 0);
        st_advance = (i == hold) && !es_flush;
        #1;
        check("rg_done",   {31'h0, st_ready_go}, 32'h1);
        check("busy_done", {31'h0, st_busy},     32'h1);
        @(posedge clk); #1;
        if (es_flush) begin
          es_flush = 1'b0;
          break;
        end
      end
    end
    st_advance = 1'b0; es_valid = 1'b0;
    check("rg_idle",   {31'h0, st_ready_go}, 32'h0);
    check("busy_idle", {31'h0, st_busy},     32'h0);
    check("req_idle",  {31'h0, data_req},    32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'h0, data_req},    32'h0);
    check({tag, "_wr"},    {31'h0, data_wr},     32'h0);
    check({tag, "_busy"},  {31'h0, st_busy},     32'h0);
    check({tag, "_rg"},    {31'h0, st_ready_go}, 32'h0);
    check({tag, "_addr"},  data_addr,            32'h0);
    check({tag, "_wdata"}, data_wdata,           32'h0);
    check({tag, "_strb"},  {28'h0, data_wstrb},  32'h0);
    check({tag, "_size"},  {30'h0, data_size},   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; es_valid = 1'b0; es_is_store = 1'b0; es_store_op = 3'd0;
    es_addr = 32'h0; es_rt_value = 32'h0; es_flush = 1'b0; st_advance = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    run_store(1, 32'h1000_0002, 32'h1234_56AB, 0, 1, 0, 1'b0, 1);
    for (int a = 0; a < 4; a++) begin
      run_store(3, 32'h2000_0040 + a, 32'hAABB_CCDD, 0, 0, 0, 1'b0, 0);
      run_store(4, 32'h2000_0080 + a, 32'hAABB_CCDD, 0, 0, 0, 1'b0, 0);
    end
    run_store(0, 32'h3000_0010, 32'hDEAD_BEEF, 5, 2, 0, 1'b0, 0);
    run_store(2, 32'h3000_0022, 32'h0000_5A5A, 2, 1, 1, 1'b0, 0);
    run_store(0, 32'h4000_0000, 32'h0123_4567, 0, 1, 0, 1'b1, 0);
    run_store(2, 32'h4000_0006, 32'h89AB_CDEF, 0, 0, 0, 1'b1, 0);
    run_store(1, 32'h5000_0001, 32'h0000_0077, 1, 2, 2, 1'b0, 0);
    run_store(4, 32'h5000_0013, 32'h1122_3344, 0, 0, 3, 1'b0, 2);
    run_store(0, 32'h5000_0020, 32'h5555_AAAA, 0, 0, 4, 1'b0, 0);

    // Reset while WAIT, then a stray data_ok in IDLE.
    es_valid = 1'b1; es_is_store = 1'b1; es_store_op = 3'd0;
    es_addr = 32'h6000_0004; es_rt_value = 32'hCAFE_F00D;
    exp_q.push_back(model(0, 32'h6000_0004, 32'hCAFE_F00D));
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; es_valid = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_wait");
    resetn = 1'b1; data_data_ok = 1'b1;
    #1;
    check("late_dataok_rg", {31'h0, st_ready_go}, 32'h0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    check("late_dataok_busy", {31'h0, st_busy},  32'h0);
    check("late_dataok_req",  {31'h0, data_req}, 32'h0);

    for (int n = 0; n < 40; n++) begin
      int op, alat, dlat, fm, hold;
      bit adv;
      logic [31:0] ad, rt;
      op = $urandom_range(0, 4); ad = $urandom; rt = $urandom;
      alat = $urandom_range(0, 3); dlat = $urandom_range(0, 3);
      adv = 1'($urandom_range(0, 1)); hold = $urandom_range(0, 2);
      fm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (fm == 2 && dlat == 0) dlat = 1;
      if (fm == 3) adv = 1'b0;
      run_store(op, ad, rt, alat, dlat, fm, adv, hold);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
